// File: rtl/chip8_pkg.sv
// Shared constants, FSM state type and built-in font image for the CHIP-8 memory subsystem.
package chip8_pkg;

    localparam int ADDR_W_DEFAULT    = 12;
    localparam int FONT_BASE_DEFAULT = 'h1b0;
    localparam int FONT_BYTES        = 80;
    localparam int PROG_BASE         = 'h200;
    localparam int LEN_W             = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } mem_state_t;

    // Glyphs 0..F, five rows each; byte 0 of the image sits in the top bits.
    localparam logic [FONT_BYTES*8-1:0] FONT_IMAGE = {
        40'hF0_90_90_90_F0, 40'h20_60_20_20_70, 40'hF0_10_F0_80_F0, 40'hF0_10_F0_10_F0,
        40'h90_90_F0_10_10, 40'hF0_80_F0_10_F0, 40'hF0_80_F0_90_F0, 40'hF0_10_20_40_40,
        40'hF0_90_F0_90_F0, 40'hF0_90_F0_10_F0, 40'hF0_90_F0_90_90, 40'hE0_90_E0_90_E0,
        40'hF0_80_80_80_F0, 40'hE0_90_90_90_E0, 40'hF0_80_F0_80_F0, 40'hF0_80_F0_80_80
    };

    function automatic logic [7:0] font_byte(input int idx);
        return FONT_IMAGE[(FONT_BYTES-1-idx)*8 +: 8];
    endfunction

endpackage

// File: rtl/chip8_rr_arbiter.sv
// Round-robin grant over NUM_PORTS requesters; the pointer moves past each granted port.
module chip8_rr_arbiter #(
    parameter int NUM_PORTS = 4,
    localparam int IDX_W    = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM_PORTS-1:0] request,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx
);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] cand;

    // Scan farthest-first so the last hit is the nearest port at or after rr_ptr.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        if (enable) begin
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                cand = IDX_W'((int'(rr_ptr) + k) % NUM_PORTS);
                if (request[cand]) begin
                    grant       = '0;
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= IDX_W'((int'(grant_idx) + 1) % NUM_PORTS);
        end
    end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Multi-port CHIP-8 main RAM with round-robin access, 1..16 byte read bursts and a font overlay.
// Define CHIP8_MEM_WPROT_EN to discard writes below PROG_BASE and add the wprot_err output.
module chip8_mem_arbiter
    import chip8_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int FONT_BASE = FONT_BASE_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req_valid,
    output logic [NUM_PORTS-1:0]        req_ready,
    input  logic [NUM_PORTS-1:0]        req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*LEN_W-1:0]  req_len,
    input  logic [NUM_PORTS*8-1:0]      req_wdata,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    output logic [7:0]                  rsp_data,
    output logic                        rsp_last,
    output logic                        busy
`ifdef CHIP8_MEM_WPROT_EN
    ,
    output logic                        wprot_err
`endif
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [NUM_PORTS-1:0] PORT_ONE = NUM_PORTS'(1);

    mem_state_t        state, state_next;
    logic [ADDR_W-1:0] base_addr, base_addr_next;
    logic [LEN_W-1:0]  beat_cnt, beat_cnt_next;
    logic [LEN_W-1:0]  beat_len, beat_len_next;
    logic [IDX_W-1:0]  owner, owner_next;

    logic [NUM_PORTS-1:0] grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 sel_write;
    logic [ADDR_W-1:0]    sel_addr;
    logic [LEN_W-1:0]     sel_len;
    logic [7:0]           sel_wdata;

    logic              accept, issue, issue_last, do_write, protect_hit;
    logic [ADDR_W-1:0] rd_addr, font_off, wr_off;
    logic              in_font;
    logic [FONT_BYTES-1:0] font_dirty;
    logic [7:0]        mem [DEPTH];

    chip8_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (state == ST_IDLE),
        .request   (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign busy      = (state == ST_BURST);
    assign sel_write = req_write[grant_idx];
    assign sel_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign sel_len   = req_len[int'(grant_idx)*LEN_W +: LEN_W];
    assign sel_wdata = req_wdata[int'(grant_idx)*8 +: 8];

    // Beat 0 is issued at the accept edge; later beats come from the saved base plus counter.
    always_comb begin
        state_next     = state;
        base_addr_next = base_addr;
        beat_cnt_next  = beat_cnt;
        beat_len_next  = beat_len;
        owner_next     = owner;
        accept         = |grant;
        issue          = 1'b0;
        issue_last     = 1'b0;
        rd_addr        = sel_addr;
        case (state)
            ST_IDLE: begin
                if (accept && !sel_write) begin
                    issue      = 1'b1;
                    issue_last = (sel_len == '0);
                    owner_next = grant_idx;
                    if (sel_len != '0) begin
                        state_next     = ST_BURST;
                        base_addr_next = sel_addr;
                        beat_cnt_next  = LEN_W'(1);
                        beat_len_next  = sel_len;
                    end
                end
            end
            ST_BURST: begin
                issue      = 1'b1;
                rd_addr    = base_addr + ADDR_W'(beat_cnt);
                issue_last = (beat_cnt == beat_len);
                if (issue_last) begin
                    state_next = ST_IDLE;
                end else begin
                    beat_cnt_next = beat_cnt + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            base_addr <= '0;
            beat_cnt  <= '0;
            beat_len  <= '0;
            owner     <= '0;
        end else begin
            state     <= state_next;
            base_addr <= base_addr_next;
            beat_cnt  <= beat_cnt_next;
            beat_len  <= beat_len_next;
            owner     <= owner_next;
        end
    end

`ifdef CHIP8_MEM_WPROT_EN
    assign protect_hit = (int'(sel_addr) < PROG_BASE);
`else
    assign protect_hit = 1'b0;
`endif
    assign do_write = accept && sel_write && !protect_hit;

    // Font bytes come from a constant image until software overwrites them, so no init file is needed.
    assign font_off = rd_addr - ADDR_W'(FONT_BASE);
    assign wr_off   = sel_addr - ADDR_W'(FONT_BASE);
    assign in_font  = (int'(font_off) < FONT_BYTES) && !font_dirty[font_off[6:0]];

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[sel_addr] <= sel_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            font_dirty <= '0;
        end else if (do_write && int'(wr_off) < FONT_BYTES) begin
            font_dirty[wr_off[6:0]] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
        end else begin
            rsp_valid <= issue ? (PORT_ONE << owner_next) : '0;
            rsp_last  <= issue_last;
            if (issue) begin
                rsp_data <= in_font ? font_byte(int'(font_off)) : mem[rd_addr];
            end
        end
    end

`ifdef CHIP8_MEM_WPROT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wprot_err <= 1'b0;
        end else begin
            wprot_err <= accept && sel_write && protect_hit;
        end
    end
`endif

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Self-checking bench for chip8_mem_arbiter: directed table, corner sequences and random traffic.
module tb_chip8_mem_arbiter;

    localparam int NP = 4;
    localparam int AW = 12;
`ifdef CHIP8_MEM_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NP-1:0]    req_valid = '0;
    logic [NP-1:0]    req_ready;
    logic [NP-1:0]    req_write = '0;
    logic [NP*AW-1:0] req_addr = '0;
    logic [NP*4-1:0]  req_len = '0;
    logic [NP*8-1:0]  req_wdata = '0;
    logic [NP-1:0]    rsp_valid;
    logic [7:0]       rsp_data;
    logic             rsp_last;
    logic             busy;
`ifdef CHIP8_MEM_WPROT_EN
    logic             wprot_err;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0] ref_mem [4096];
    bit         known   [4096];
    logic [7:0] font    [80];

    typedef struct {
        int port;
        bit wr;
        int addr;
        int len;
        int wdata;
        bit has_exp;
        int exp_first;
        int exp_last;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    chip8_mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .FONT_BASE('h1b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy)
`ifdef CHIP8_MEM_WPROT_EN
        ,
        .wprot_err (wprot_err)
`endif
    );

    task automatic check_output(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int p, input bit wr, input int addr, input int len, input int wdata);
        req_valid[p]          = 1'b1;
        req_write[p]          = wr;
        req_addr[p*AW +: AW]  = AW'(addr);
        req_len[p*4 +: 4]     = 4'(len);
        req_wdata[p*8 +: 8]   = 8'(wdata);
    endtask

    // Called at +1 after an edge; returns at +2 of the cycle whose edge will accept port p.
    task automatic wait_grant(input int p);
        int n = 0;
        #1;
        while (req_ready[p] !== 1'b1 && n < 64) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_output($sformatf("grant_p%0d", p), int'(n < 64), 1);
        check_output("ready_onehot", int'(req_ready), 1 << p);
    endtask

    task automatic do_write(input int p, input int addr, input int data);
        bit prot;
        prot = WPROT && (addr < 'h200);
        apply_stimulus(p, 1'b1, addr, 0, data);
        wait_grant(p);
        tick();
        req_valid[p] = 1'b0;
        check_output("wr_no_rsp", int'(rsp_valid), 0);
`ifdef CHIP8_MEM_WPROT_EN
        check_output("wprot_err", int'(wprot_err), int'(prot));
`endif
        if (!prot) begin
            ref_mem[addr % 4096] = 8'(data);
            known[addr % 4096]   = 1'b1;
        end
    endtask

    task automatic do_read(input int p, input int addr, input int len,
                           output logic [7:0] first, output logic [7:0] last);
        int a;
        first = '0;
        last  = '0;
        apply_stimulus(p, 1'b0, addr, len, 0);
        wait_grant(p);
        tick();
        req_valid[p] = 1'b0;
        for (int k = 0; k <= len; k++) begin
            a = (addr + k) % 4096;
            check_output("rsp_valid", int'(rsp_valid), 1 << p);
            check_output("rsp_last", int'(rsp_last), int'(k == len));
            check_output("busy", int'(busy), int'(k < len));
            if (known[a]) check_output($sformatf("rsp_data@%0h", a), int'(rsp_data), int'(ref_mem[a]));
            if (k == 0) first = rsp_data;
            last = rsp_data;
            tick();
        end
        check_output("rsp_idle", int'(rsp_valid), 0);
    endtask

    initial begin
        logic [7:0] f, l;
        int order [4] = '{0, 1, 3, 0};
        int raddr [4] = '{'h1b0, 'h1b5, 'h1b6, 'h1b0};

        font = '{8'hF0,8'h90,8'h90,8'h90,8'hF0, 8'h20,8'h60,8'h20,8'h20,8'h70,
                 8'hF0,8'h10,8'hF0,8'h80,8'hF0, 8'hF0,8'h10,8'hF0,8'h10,8'hF0,
                 8'h90,8'h90,8'hF0,8'h10,8'h10, 8'hF0,8'h80,8'hF0,8'h10,8'hF0,
                 8'hF0,8'h80,8'hF0,8'h90,8'hF0, 8'hF0,8'h10,8'h20,8'h40,8'h40,
                 8'hF0,8'h90,8'hF0,8'h90,8'hF0, 8'hF0,8'h90,8'hF0,8'h10,8'hF0,
                 8'hF0,8'h90,8'hF0,8'h90,8'h90, 8'hE0,8'h90,8'hE0,8'h90,8'hE0,
                 8'hF0,8'h80,8'h80,8'h80,8'hF0, 8'hE0,8'h90,8'h90,8'h90,8'hE0,
                 8'hF0,8'h80,8'hF0,8'h80,8'hF0, 8'hF0,8'h80,8'hF0,8'h80,8'h80};
        for (int i = 0; i < 80; i++) begin
            ref_mem['h1b0 + i] = font[i];
            known['h1b0 + i]   = 1'b1;
        end

        // Reset state
        repeat (3) tick();
        check_output("rst_ready", int'(req_ready), 0);
        check_output("rst_rsp_valid", int'(rsp_valid), 0);
        check_output("rst_rsp_data", int'(rsp_data), 0);
        check_output("rst_rsp_last", int'(rsp_last), 0);
        check_output("rst_busy", int'(busy), 0);
`ifdef CHIP8_MEM_WPROT_EN
        check_output("rst_wprot_err", int'(wprot_err), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed table
        vecs.push_back('{0, 1'b0, 'h1b0, 4, 0,     1'b1,   'hF0, 'hF0});
        vecs.push_back('{1, 1'b1, 'h300, 0, 'hA5,  1'b0,   0,    0});
        vecs.push_back('{2, 1'b0, 'h300, 0, 0,     1'b1,   'hA5, 'hA5});
        vecs.push_back('{0, 1'b1, 'hFFE, 0, 'h11,  1'b0,   0,    0});
        vecs.push_back('{1, 1'b1, 'hFFF, 0, 'h22,  1'b0,   0,    0});
        vecs.push_back('{2, 1'b1, 'h000, 0, 'h33,  1'b0,   0,    0});
        vecs.push_back('{3, 1'b1, 'h001, 0, 'h44,  1'b0,   0,    0});
        vecs.push_back('{3, 1'b0, 'hFFE, 3, 0,     !WPROT, 'h11, 'h44});
        vecs.push_back('{1, 1'b0, 'h1b5, 1, 0,     1'b1,   'h20, 'h60});
        vecs.push_back('{0, 1'b0, 'h1ec, 4, 0,     1'b1,   'hF0, 'hF0});
        vecs.push_back('{2, 1'b0, 'h1fb, 4, 0,     1'b1,   'hF0, 'h80});
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].port, vecs[i].addr, vecs[i].wdata);
            end else begin
                do_read(vecs[i].port, vecs[i].addr, vecs[i].len, f, l);
                if (vecs[i].has_exp) begin
                    check_output($sformatf("vec%0d_first", i), int'(f), vecs[i].exp_first);
                    check_output($sformatf("vec%0d_last", i), int'(l), vecs[i].exp_last);
                end
            end
        end

        // Write to the interpreter area
`ifdef CHIP8_MEM_WPROT_EN
        do_read(0, 'h050, 0, f, l);
        ref_mem['h050] = f;
        known['h050]   = 1'b1;
`endif
        do_write(1, 'h050, 'hFF);
        do_read(2, 'h050, 0, f, l);
        check_output("wprot_readback", int'(f), WPROT ? int'(ref_mem['h050]) : 'hFF);

        // Fill a working window with known data
        for (int a = 'h600; a < 'h700; a++) begin
            do_write($urandom_range(0, NP-1), a, $urandom_range(0, 255));
        end

        // Next request waits out a burst and is accepted while the last byte is presented
        apply_stimulus(0, 1'b0, 'h610, 2, 0);
        wait_grant(0);
        tick();
        req_valid[0] = 1'b0;
        apply_stimulus(1, 1'b0, 'h620, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check_output($sformatf("b2b_ready%0d", k), int'(req_ready), (k == 2) ? 2 : 0);
            check_output("b2b_data", int'(rsp_data), int'(ref_mem['h610 + k]));
            check_output("b2b_valid", int'(rsp_valid), 1);
            tick();
        end
        req_valid[1] = 1'b0;
        check_output("b2b_next_valid", int'(rsp_valid), 2);
        check_output("b2b_next_data", int'(rsp_data), int'(ref_mem['h620]));
        check_output("b2b_next_last", int'(rsp_last), 1);
        tick();
        check_output("b2b_idle", int'(rsp_valid), 0);

        // Reset during beat 2 of a 16-byte burst
        apply_stimulus(2, 1'b0, 'h640, 15, 0);
        wait_grant(2);
        tick();
        req_valid[2] = 1'b0;
        tick();
        tick();
        check_output("abort_beat2_valid", int'(rsp_valid), 4);
        check_output("abort_beat2_data", int'(rsp_data), int'(ref_mem['h642]));
        rst_n = 1'b0;
        #1;
        check_output("abort_rsp_valid", int'(rsp_valid), 0);
        check_output("abort_busy", int'(busy), 0);
        tick();
        check_output("abort_hold_valid", int'(rsp_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_output("abort_after_valid", int'(rsp_valid), 0);
        check_output("abort_after_busy", int'(busy), 0);

        // Round-robin order with pointer back at 0: ports 0,1,3 then 0 again
        apply_stimulus(0, 1'b0, raddr[0], 0, 0);
        apply_stimulus(1, 1'b0, raddr[1], 0, 0);
        apply_stimulus(3, 1'b0, raddr[2], 0, 0);
        #1;
        for (int s = 0; s < 4; s++) begin
            check_output($sformatf("rr_ready%0d", s), int'(req_ready), 1 << order[s]);
            tick();
            check_output($sformatf("rr_rsp%0d", s), int'(rsp_valid), 1 << order[s]);
            check_output($sformatf("rr_data%0d", s), int'(rsp_data), int'(ref_mem[raddr[s]]));
            req_valid[order[s]] = 1'b0;
            if (s == 2) begin
                apply_stimulus(0, 1'b0, raddr[3], 0, 0);
                apply_stimulus(1, 1'b0, raddr[1], 0, 0);
            end
            if (s == 3) req_valid = '0;
            #1;
        end
        tick();
        check_output("rr_idle", int'(rsp_valid), 0);

        // RAM kept its contents across the aborted burst
        do_read(0, 'h640, 15, f, l);

        // Random traffic inside the window against the reference memory
        for (int i = 0; i < 120; i++) begin
            int p, len, addr;
            p = $urandom_range(0, NP-1);
            if ($urandom_range(0, 2) == 0) begin
                do_write(p, 'h600 + $urandom_range(0, 255), $urandom_range(0, 255));
            end else begin
                len  = $urandom_range(0, 15);
                addr = 'h600 + $urandom_range(0, 255 - len);
                do_read(p, addr, len, f, l);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
